// File: rtl/enflasyon_uretici_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | enflasyon_uretici_if                                             |
// | Price-index input handshake and monthly inflation output bundle. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface enflasyon_uretici_if #(
    parameter int FIYAT_W = 16,
    parameter int ENF_W   = 4
);
    logic [FIYAT_W-1:0] fiyat;
    logic               fiyat_gecerli;
    logic               fiyat_hazir;
    logic [ENF_W-1:0]   enflasyon;
    logic               enflasyon_gecerli;
    logic               tasma;

    // master feeds prices and consumes inflation; slave is the producer block
    modport master (
        output fiyat, fiyat_gecerli,
        input  fiyat_hazir, enflasyon, enflasyon_gecerli, tasma
    );

    modport slave (
        input  fiyat, fiyat_gecerli,
        output fiyat_hazir, enflasyon, enflasyon_gecerli, tasma
    );
endinterface
`default_nettype wire

// File: rtl/enflasyon_uretici.sv
`default_nettype none
// +------------------------------------------------------------------+
// | enflasyon_uretici                                                |
// | Monthly percentage increase of a price index, computed with a    |
// | sequential restoring divider; truncated, clamped and saturated.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module enflasyon_uretici #(
    parameter int FIYAT_W = 16,
    parameter int ENF_W   = 4
) (
    input  logic                saat,
    input  logic                reset,
    enflasyon_uretici_if.slave  bus
);

    localparam int c_PAY_W = FIYAT_W + 7;
    localparam int c_SAY_W = $clog2(c_PAY_W);

    localparam logic [c_SAY_W-1:0] c_SON_BIT = c_SAY_W'(c_PAY_W - 1);
    localparam logic [c_PAY_W-1:0] c_YUZ     = c_PAY_W'(100);
    localparam logic [ENF_W-1:0]   c_DOYMA   = '1;

    localparam logic [1:0] c_BOS   = 2'd0;
    localparam logic [1:0] c_HAZIR = 2'd1;
    localparam logic [1:0] c_BOL   = 2'd2;
    localparam logic [1:0] c_YAZ   = 2'd3;

    logic [1:0]          r_durum;
    logic [1:0]          w_sonraki;
    logic                w_hazir;

    logic [FIYAT_W-1:0]  r_eski;
    logic [FIYAT_W-1:0]  r_yeni;
    logic [c_PAY_W-1:0]  r_pay;
    logic [FIYAT_W-1:0]  r_kalan;
    logic [c_SAY_W-1:0]  r_say;

    logic [ENF_W-1:0]    r_enf;
    logic                r_enf_gecerli;
    logic                r_tasma;

    logic                w_kabul;
    logic                w_sifir;
    logic [FIYAT_W-1:0]  w_artis;
    logic [c_PAY_W-1:0]  w_pay;
    logic [FIYAT_W:0]    w_kaydir;
    logic                w_cikar;
    logic [FIYAT_W-1:0]  w_fark;
    logic                w_doyma;

    assign w_kabul = bus.fiyat_gecerli && w_hazir;
    assign w_sifir = (bus.fiyat == '0);
    assign w_artis = bus.fiyat - r_eski;
    assign w_pay   = (bus.fiyat > r_eski) ? c_PAY_W'(w_artis) * c_YUZ : '0;

    // Partial remainder is always below the divisor, so the low FIYAT_W
    // bits of the difference are exact.
    assign w_kaydir = {r_kalan, r_pay[c_PAY_W-1]};
    assign w_cikar  = (w_kaydir >= {1'b0, r_eski});
    assign w_fark   = w_kaydir[FIYAT_W-1:0] - r_eski;
    assign w_doyma  = |r_pay[c_PAY_W-1:ENF_W];

    always_ff @(posedge saat) begin
        if (!reset) begin
            r_durum <= c_BOS;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    always_comb begin
        w_sonraki = r_durum;
        w_hazir   = 1'b0;
        case (r_durum)
            c_BOS: begin
                w_hazir = 1'b1;
                if (w_kabul && !w_sifir) w_sonraki = c_HAZIR;
            end
            c_HAZIR: begin
                w_hazir = 1'b1;
                if (w_kabul && !w_sifir) w_sonraki = c_BOL;
            end
            c_BOL: begin
                if (r_say == c_SON_BIT) w_sonraki = c_YAZ;
            end
            c_YAZ: begin
                w_sonraki = c_HAZIR;
            end
            default: begin
                w_sonraki = c_BOS;
            end
        endcase
    end

    always_ff @(posedge saat) begin
        if (!reset) begin
            r_eski        <= '0;
            r_yeni        <= '0;
            r_pay         <= '0;
            r_kalan       <= '0;
            r_say         <= '0;
            r_enf         <= '0;
            r_enf_gecerli <= 1'b0;
            r_tasma       <= 1'b0;
        end else begin
            r_enf_gecerli <= 1'b0;
            case (r_durum)
                c_BOS: begin
                    if (w_kabul && !w_sifir) r_eski <= bus.fiyat;
                end
                c_HAZIR: begin
                    if (w_kabul && !w_sifir) begin
                        r_yeni  <= bus.fiyat;
                        r_pay   <= w_pay;
                        r_kalan <= '0;
                        r_say   <= '0;
                    end
                end
                c_BOL: begin
                    // Numerator shifts out MSB first; quotient bits fill from the LSB.
                    r_pay   <= {r_pay[c_PAY_W-2:0], w_cikar};
                    r_kalan <= w_cikar ? w_fark : w_kaydir[FIYAT_W-1:0];
                    r_say   <= r_say + 1'b1;
                end
                c_YAZ: begin
                    r_enf         <= w_doyma ? c_DOYMA : r_pay[ENF_W-1:0];
                    r_tasma       <= w_doyma;
                    r_enf_gecerli <= 1'b1;
                    r_eski        <= r_yeni;
                end
                default: begin
                    r_enf_gecerli <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fiyat_hazir       = w_hazir;
    assign bus.enflasyon         = r_enf;
    assign bus.enflasyon_gecerli = r_enf_gecerli;
    assign bus.tasma             = r_tasma;

endmodule
`default_nettype wire

// File: tb/tb_enflasyon_uretici.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_enflasyon_uretici                                             |
// | Directed and randomized price streams against an arithmetic model|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_enflasyon_uretici;

    localparam int c_LAT = 24;

    logic saat  = 1'b0;
    logic reset = 1'b0;

    enflasyon_uretici_if #(.FIYAT_W(16), .ENF_W(4)) bus ();

    enflasyon_uretici #(.FIYAT_W(16), .ENF_W(4)) u_dut (
        .saat  (saat),
        .reset (reset),
        .bus   (bus)
    );

    always #5 saat = ~saat;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: 0 means no reference price yet
    int m_ref = 0;
    int m_enf = 0;
    int m_tas = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic xfer(input int p);
        int n = 0;
        @(negedge saat);
        while (!bus.fiyat_hazir && n < 200) begin
            @(negedge saat);
            n++;
        end
        check_val("hazir_wait", int'(bus.fiyat_hazir), 1);
        bus.fiyat         = 16'(p);
        bus.fiyat_gecerli = 1'b1;
        @(posedge saat);
        #1;
        bus.fiyat_gecerli = 1'b0;
        bus.fiyat         = 16'($urandom);
    endtask

    task automatic do_price(input int p, input bit junk);
        longint pct;
        int     e_enf;
        int     e_tas;
        bit     bad_h;
        bit     bad_p;
        xfer(p);
        if (p == 0 || m_ref == 0) begin
            if (p != 0) m_ref = p;
            @(negedge saat);
            check_val("idle_hazir", int'(bus.fiyat_hazir), 1);
            check_val("idle_pulse", int'(bus.enflasyon_gecerli), 0);
            check_val("idle_enf", int'(bus.enflasyon), m_enf);
        end else begin
            pct   = (p > m_ref) ? (longint'(p - m_ref) * 100) / m_ref : 0;
            e_tas = (pct > 15) ? 1 : 0;
            e_enf = (pct > 15) ? 15 : int'(pct);
            bad_h = 1'b0;
            bad_p = 1'b0;
            for (int k = 1; k <= c_LAT; k++) begin
                @(posedge saat);
                #1;
                if (k < c_LAT && junk) begin
                    bus.fiyat_gecerli = 1'b1;
                    bus.fiyat         = 16'($urandom);
                end else begin
                    bus.fiyat_gecerli = 1'b0;
                end
                @(negedge saat);
                if (k < c_LAT) begin
                    if (bus.fiyat_hazir) bad_h = 1'b1;
                    if (bus.enflasyon_gecerli) bad_p = 1'b1;
                    if (k == 1) check_val("busy_enf_held", int'(bus.enflasyon), m_enf);
                end
            end
            check_val("busy_hazir", int'(bad_h), 0);
            check_val("early_pulse", int'(bad_p), 0);
            check_val("pulse", int'(bus.enflasyon_gecerli), 1);
            check_val("enf", int'(bus.enflasyon), e_enf);
            check_val("tasma", int'(bus.tasma), e_tas);
            check_val("hazir_after", int'(bus.fiyat_hazir), 1);
            @(negedge saat);
            check_val("pulse_end", int'(bus.enflasyon_gecerli), 0);
            check_val("enf_hold", int'(bus.enflasyon), e_enf);
            m_ref = p;
            m_enf = e_enf;
            m_tas = e_tas;
        end
    endtask

    initial begin
        int r;
        int p;
        bit bad_p;
        bus.fiyat         = '0;
        bus.fiyat_gecerli = 1'b0;
        repeat (2) @(posedge saat);
        #1 reset = 1'b1;
        @(negedge saat);
        check_val("rst_enf", int'(bus.enflasyon), 0);
        check_val("rst_tasma", int'(bus.tasma), 0);
        check_val("rst_pulse", int'(bus.enflasyon_gecerli), 0);
        check_val("rst_hazir", int'(bus.fiyat_hazir), 1);

        do_price(100, 1'b0);
        do_price(103, 1'b0);
        repeat (5) @(negedge saat);
        check_val("hold_enf", int'(bus.enflasyon), 3);
        do_price(106, 1'b1);
        do_price(200, 1'b0);
        do_price(201, 1'b1);
        do_price(100, 1'b0);
        do_price(130, 1'b1);
        do_price(120, 1'b1);
        do_price(100, 1'b0);
        do_price(0, 1'b0);
        do_price(110, 1'b1);
        do_price(100, 1'b0);

        // Abort a division in flight
        xfer(150);
        repeat (10) @(posedge saat);
        #1 reset = 1'b0;
        @(posedge saat);
        #1 reset = 1'b1;
        m_ref = 0;
        m_enf = 0;
        m_tas = 0;
        bad_p = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge saat);
            if (bus.enflasyon_gecerli) bad_p = 1'b1;
        end
        check_val("abort_pulse", int'(bad_p), 0);
        check_val("abort_enf", int'(bus.enflasyon), 0);
        check_val("abort_tasma", int'(bus.tasma), 0);
        check_val("abort_hazir", int'(bus.fiyat_hazir), 1);
        do_price(50, 1'b0);
        do_price(55, 1'b0);

        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            if (m_ref == 0 || r == 5 || r == 6) begin
                p = int'($urandom_range(1, 65535));
            end else if (r == 0) begin
                p = 0;
            end else if (r <= 4) begin
                p = m_ref + int'($urandom_range(0, m_ref / 5));
            end else begin
                p = m_ref - int'($urandom_range(0, m_ref / 10));
            end
            if (p > 65535) p = 65535;
            if (r != 0 && p == 0) p = 1;
            do_price(p, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
